// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC and issues one read per cycle to a synchronous instruction
// memory with a fixed 1-cycle latency. Each returned word is presented to
// decode with its PC over a valid/ready handshake. The block also handles
// back-pressure, branch/jump redirects and halt requests.
//
// Optional build macro: FETCH_SKID_EN
//   defined     - a one-entry skid register catches a word that decode cannot
//                 take, so fetch resumes without a replay bubble.
//   not defined - a word that cannot be taken is dropped and its address is
//                 fetched again (replay).
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | issuing one read per cycle, PC advancing by PC_STEP
// STALL | output blocked by decode; no new reads issued
// HALT  | halt requested; no new reads, an in-flight read still lands

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_en,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        halted
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        inflight;
    logic [31:0] tag;
    logic        can_accept;
    logic        land_ok;
    logic        land_blocked;
    logic        issue;
    logic        skid_valid;

`ifdef FETCH_SKID_EN
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
`else
    assign skid_valid = 1'b0;
`endif

    assign mem_addr = pc;

    // Qualifiers for the word coming back from memory this cycle.
    always_comb begin
        can_accept   = !inst_valid || inst_ready;
        land_ok      = inflight && can_accept;
        land_blocked = inflight && !can_accept;
    end

    // Issue decision. A blocked landing suppresses the issue so that at most
    // one word is ever waiting outside the output register. A full skid only
    // issues in the cycle it drains, which keeps the resume free of bubbles.
    always_comb begin
        issue = 1'b0;
        if (!halt_req) begin
            if (skid_valid) begin
                issue = (state != ST_HALT) && can_accept;
            end else begin
                issue = (state == ST_RUN) && !land_blocked;
            end
        end
        mem_en = issue && !rst;
    end

    // Next PC: sequential advance on issue; replay rewinds to a dropped word.
    always_comb begin
        pc_nxt = pc;
        if (issue) begin
            pc_nxt = pc + PC_STEP;
        end
`ifdef FETCH_SKID_EN
        // The skid keeps the blocked word, so the PC never moves backwards.
`else
        if (land_blocked) begin
            pc_nxt = tag;
        end
`endif
    end

    // Next state. A halt request overrides everything except redirect/reset.
    always_comb begin
        state_nxt = state;
        if (halt_req) begin
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_RUN: begin
                    if (land_blocked || (skid_valid && !can_accept)) begin
                        state_nxt = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (can_accept) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_nxt = ST_RUN;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Sequencer registers: state, PC, in-flight tracking and halt status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            inflight <= 1'b0;
            tag      <= 32'h0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            state    <= halt_req ? ST_HALT : ST_RUN;
            pc       <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            halted   <= halt_req;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inflight <= issue;
            if (issue) begin
                tag <= pc;
            end
            halted   <= (state_nxt == ST_HALT) && !issue;
        end
    end

    // Output register toward decode; the skid always drains ahead of memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst_out   <= 32'h0;
            pc_out     <= 32'h0;
        end else if (redirect_valid) begin
            inst_valid <= 1'b0;
        end else if (can_accept) begin
`ifdef FETCH_SKID_EN
            if (skid_valid) begin
                inst_valid <= 1'b1;
                inst_out   <= skid_inst;
                pc_out     <= skid_pc;
            end else if (land_ok) begin
`else
            if (land_ok) begin
`endif
                inst_valid <= 1'b1;
                inst_out   <= mem_rdata;
                pc_out     <= tag;
            end else begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_SKID_EN
    // Skid entry: catches a landing word that decode cannot take this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_inst  <= 32'h0;
            skid_pc    <= 32'h0;
        end else if (redirect_valid) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && can_accept) begin
            skid_valid <= 1'b0;
        end else if (land_blocked) begin
            skid_valid <= 1'b1;
            skid_inst  <= mem_rdata;
            skid_pc    <= tag;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations followed
// by randomized ready/redirect/halt/reset traffic. A stream model tracks the
// PC decode must see next and checks every presented instruction against it.

module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;
`ifdef FETCH_SKID_EN
    localparam int EXP_BUBBLES = 0;
`else
    localparam int EXP_BUBBLES = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_en;
    logic [31:0] mem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;

    fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
    endfunction

    // Instruction memory: one-cycle read latency, garbage when not enabled.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? memf(mem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Stream model: presented instructions must follow program order from
    // the last reset or redirect, one PC_STEP apart, never skipped or repeated.
    logic        rst_q = 1'b1;
    logic [31:0] exp_pc = RESET_PC;
    logic        pv_stall = 1'b0;
    logic        pv_redirect = 1'b0;
    logic [31:0] pv_pc = 32'h0;
    logic [31:0] pv_inst = 32'h0;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (rst_q) begin
            if (rst) begin
                chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
                chk("rst_valid", {31'h0, inst_valid}, 32'h0);
                chk("rst_halted", {31'h0, halted}, 32'h0);
                chk("rst_mem_addr", mem_addr, RESET_PC);
                chk("rst_pc_out", pc_out, 32'h0);
                chk("rst_inst_out", inst_out, 32'h0);
            end else begin
                chk("release_valid", {31'h0, inst_valid}, 32'h0);
                chk("release_addr", mem_addr, RESET_PC);
            end
            exp_pc = RESET_PC;
        end else begin
            if (pv_redirect) chk("flush_valid", {31'h0, inst_valid}, 32'h0);
            if (pv_stall) begin
                chk("hold_valid", {31'h0, inst_valid}, 32'h1);
                chk("hold_pc", pc_out, pv_pc);
                chk("hold_inst", inst_out, pv_inst);
            end
            if (inst_valid) begin
                chk("stream_pc", pc_out, exp_pc);
                chk("stream_inst", inst_out, memf(pc_out));
            end
            if (halt_req || halted) chk("halt_no_issue", {31'h0, mem_en}, 32'h0);
        end
        if (!rst) begin
            if (inst_valid && inst_ready) begin
                exp_pc = exp_pc + PC_STEP;
                hs_count++;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        pv_stall    = !rst && inst_valid && !inst_ready && !redirect_valid;
        pv_redirect = !rst && redirect_valid;
        pv_pc       = pc_out;
        pv_inst     = inst_out;
    end

    initial begin
        int bub;
        int base;
        rst = 1'b1;
        inst_ready = 1'b1;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        // Reset values, then the first sequential stream.
        repeat (3) go();
        smp();
        chk("A_rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("A_rst_addr", mem_addr, 32'h0);
        go();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            smp();
            if (k == 0) begin
                chk("A_first_en", {31'h0, mem_en}, 32'h1);
                chk("A_first_addr", mem_addr, 32'h0);
            end
            if (k < 2) chk("A_lat_valid", {31'h0, inst_valid}, 32'h0);
            else begin
                chk("A_valid", {31'h0, inst_valid}, 32'h1);
                chk("A_pc", pc_out, 32'((k - 2) * 4));
                chk("A_inst", inst_out, memf(32'((k - 2) * 4)));
            end
            go();
        end

        // Back-pressure for 3 cycles while pc_out = 8.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        go();
        redirect_valid = 1'b0;
        repeat (4) go();
        inst_ready = 1'b0;
        smp();
        chk("B_stall_pc0", pc_out, 32'h8);
        go();
        smp();
        chk("B_stall_pc1", pc_out, 32'h8);
        go();
        smp();
        chk("B_stall_pc2", pc_out, 32'h8);
        go();
        inst_ready = 1'b1;
        smp();
        chk("B_release_pc", pc_out, 32'h8);
        chk("B_release_valid", {31'h0, inst_valid}, 32'h1);
        go();
        bub = 0;
        for (int i = 0; i < 8; i++) begin
            smp();
            if (inst_valid) break;
            bub++;
            go();
        end
        chk("B_bubbles", 32'(bub), 32'(EXP_BUBBLES));
        chk("B_pc12", pc_out, 32'hC);
        go();
        smp();
        chk("B_pc16", pc_out, 32'h10);

        // Redirect to 0x40 while stalled.
        go();
        inst_ready = 1'b0;
        go();
        go();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        go();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        smp();
        chk("C_flush_valid", {31'h0, inst_valid}, 32'h0);
        chk("C_target_addr", mem_addr, 32'h40);
        go();
        smp();
        chk("C_t2_valid", {31'h0, inst_valid}, 32'h0);
        go();
        smp();
        chk("C_t3_valid", {31'h0, inst_valid}, 32'h1);
        chk("C_t3_pc", pc_out, 32'h40);
        go();
        smp();
        chk("C_t4_pc", pc_out, 32'h44);

        // Unaligned redirect target.
        go();
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        go();
        redirect_valid = 1'b0;
        go();
        go();
        smp();
        chk("D_pc40", pc_out, 32'h40);
        go();
        smp();
        chk("D_pc44", pc_out, 32'h44);

        // PC wrap-around.
        go();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        go();
        redirect_valid = 1'b0;
        go();
        go();
        smp();
        chk("E_pc_fff8", pc_out, 32'hFFFF_FFF8);
        go();
        smp();
        chk("E_pc_fffc", pc_out, 32'hFFFF_FFFC);
        go();
        smp();
        chk("E_pc_0", pc_out, 32'h0);

        // Halt mid-stream and resume.
        go();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        go();
        redirect_valid = 1'b0;
        go();
        go();
        smp();
        chk("F_pc100", pc_out, 32'h100);
        go();
        halt_req = 1'b1;
        smp();
        chk("F_en_fall", {31'h0, mem_en}, 32'h0);
        chk("F_pc104", pc_out, 32'h104);
        go();
        smp();
        chk("F_halted", {31'h0, halted}, 32'h1);
        chk("F_pc108", pc_out, 32'h108);
        go();
        smp();
        chk("F_drained", {31'h0, inst_valid}, 32'h0);
        go();
        go();
        halt_req = 1'b0;
        go();
        smp();
        chk("F_unhalted", {31'h0, halted}, 32'h0);
        chk("F_resume_en", {31'h0, mem_en}, 32'h1);
        chk("F_resume_addr", mem_addr, 32'h10C);
        for (int i = 0; i < 6; i++) begin
            go();
            smp();
            if (inst_valid) break;
        end
        chk("F_resume_pc", pc_out, 32'h10C);

        // Reset while stalled (skid full when present).
        go();
        inst_ready = 1'b0;
        repeat (3) go();
        rst = 1'b1;
        go();
        go();
        smp();
        chk("G_rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("G_rst_addr", mem_addr, RESET_PC);
        go();
        rst = 1'b0;
        inst_ready = 1'b1;
        smp();
        chk("G_first_en", {31'h0, mem_en}, 32'h1);
        chk("G_first_addr", mem_addr, RESET_PC);
        go();
        go();
        smp();
        chk("G_first_pc", pc_out, RESET_PC);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            go();
            inst_ready = ($urandom_range(0, 9) < 7);
            if (rst) begin
                rst = 1'b0;
                redirect_valid = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                redirect_valid = 1'b0;
            end else begin
                redirect_valid = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 3) == 0)
                    redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
                else
                    redirect_pc = $urandom;
            end
            if (halt_req) begin
                if ($urandom_range(0, 9) == 0) halt_req = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                halt_req = 1'b1;
            end
        end

        // Free-flowing tail: throughput must reach one instruction per cycle.
        go();
        rst = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        repeat (5) go();
        base = hs_count;
        repeat (20) go();
        smp();
        checks++;
        if (hs_count - base < 18) begin
            failures++;
            $display("FAIL throughput actual=%0d required>=18", hs_count - base);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller for the instruction-fetch path. Owns the program counter and sequences the synchronous instruction memory, one request per cycle. Delivers each instruction with its PC to decode over a valid/ready handshake. Handles back-pressure, branch/jump redirects and a halt request, replacing the free-running PC+adder loop with a controlled sequencer.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `PC_STEP`, default 4: increment between sequential fetches.
- `clk` input 1: rising-edge clock; all state updates on this edge.
- `rst` input 1: reset, synchronous, active-high.
- `mem_addr` output 32: instruction memory address (`Dir`), registered PC.
- `mem_en` output 1: a read is issued this cycle at `mem_addr`.
- `mem_rdata` input 32: memory data (`Inst`), valid the cycle after an issued read.
- `redirect_valid` input 1: single-cycle branch/jump request.
- `redirect_pc` input 32: redirect target; bits [1:0] are forced to 0.
- `halt_req` input 1: level request to stop fetching.
- `inst_valid` output 1: `inst_out`/`pc_out` hold a valid instruction.
- `inst_ready` input 1: decode accepts the instruction this cycle.
- `inst_out` output 32: instruction to decode.
- `pc_out` output 32: address of `inst_out`.
- `halted` output 1: halt state reached, with no read in flight.

## Operation
- Memory read latency is fixed at 1 cycle. An in-flight flag and tag register record the address of each issued read.
- Acceptance condition: `can_accept = !inst_valid || inst_ready`.
  - Returning data is written to the output register when `can_accept` is true.
  - A handshake completes when `inst_valid && inst_ready`.
- States:
  - RUN: `mem_en=1`; PC advances by `PC_STEP` each cycle a read is issued.
  - STALL: output is blocked; `mem_en=0`.
  - HALT: `mem_en=0`.
- RUN→STALL: returning data cannot be accepted.
  - Without skid: the data is dropped and PC rewinds to the dropped address (replay).
  - With skid: see Configuration.
- STALL→RUN: in the cycle after `can_accept` becomes true.
- RUN/STALL→HALT: `halt_req`=1 stops new issues. An in-flight read still lands under the normal accept rules.
- `halted`=1 once no read is in flight. HALT→RUN when `halt_req`=0, continuing at the held PC.
- Redirect (priority over stall and halt; takes effect at the clock edge):
  - Loads PC with `redirect_pc`.
  - Clears the in-flight flag, `inst_valid` and the skid register.
  - State becomes RUN, or HALT if `halt_req`=1.
  - A simultaneous `inst_valid && inst_ready` handshake still completes; flushed data is never presented.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- Reset values:
  - Outputs: `mem_addr`=RESET_PC, `mem_en`=0, `inst_valid`=0, `inst_out`=0, `pc_out`=0, `halted`=0.
  - Internal: in-flight flag and skid cleared; state RUN.
- Reset asserted mid-operation discards all in-flight and buffered data at that edge.

## Timing
- First read is issued in the first cycle after `rst` deasserts, at RESET_PC. `inst_valid` rises 2 cycles later.
- Steady state with `inst_ready`=1: one instruction per cycle and consecutive `pc_out` values.
- Redirect seen in cycle t:
  - `inst_valid`=0 at t+1.
  - `mem_addr`=target at t+1.
  - Target instruction is valid at t+3.
- Replay penalty (no skid): 2 bubble cycles after `inst_ready` returns.
- `mem_en` is combinational from state, the in-flight flag and skid occupancy. Every other output is registered.

## Configuration
- `FETCH_SKID_EN` defined:
  - A one-entry skid register (instruction + PC) captures data that cannot be accepted.
  - No replay occurs. `mem_en`=0 while the skid is full.
  - On resume, the skid drains into the output first, then sequential fetch continues.
  - Bubble after `inst_ready` returns: 0 cycles.
- Not defined: no skid register; stalls use replay as described under Operation.

## Test plan
- Reset release with RESET_PC=0 and `inst_ready`=1 → `pc_out` reads 0, 4, 8, 12 on consecutive cycles, the first 2 cycles after release; instructions match memory.
- `inst_ready`=0 for 3 cycles while `pc_out`=8 → output holds 8; after release `pc_out` runs 12, 16 with no PC skipped or duplicated, in both macro settings. Bubble count is 2 without skid and 0 with it.
- `redirect_valid` with `redirect_pc`=32'h40 while a stall is active → `inst_valid`=0 next cycle; the next valid `pc_out` is 0x40; no pre-redirect instruction is presented.
- `redirect_pc`=32'h43 → fetch proceeds at 0x40, then 0x44.
- PC at 32'hFFFF_FFF8 → `pc_out` reads FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `halt_req`=1 mid-stream → `mem_en` falls the same cycle; `halted`=1 after the in-flight read lands. Deasserting `halt_req` resumes at the next sequential PC.
- Reset asserted while stalled with the skid full → all outputs take their reset values; first fetch after release is at RESET_PC.
